// File: rtl/store_commit_buffer_pkg.sv
// Shared types for the post-commit store buffer: access sizes, drain FSM
// states and the per-entry payload held in the FIFO.
package store_commit_buffer_pkg;

  localparam int unsigned SCB_DATA_W = 32;
  localparam int unsigned SCB_STRB_W = SCB_DATA_W / 8;

  // Encoding matches the ROB size field; 2'b11 is never legal.
  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } st_size_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } scb_state_t;

  // Lane-replicated data and byte enables, ready to drive onto the memory port.
  typedef struct packed {
    logic [SCB_DATA_W-1:0] wdata;
    logic [SCB_STRB_W-1:0] wstrb;
  } scb_entry_t;

  // Only an aligned word store enables all four lanes, so a full strobe
  // identifies an entry that can satisfy a word load on its own.
  function automatic logic is_full_word(input logic [SCB_STRB_W-1:0] strb);
    return strb == '1;
  endfunction

endpackage

// File: rtl/store_commit_buffer_lane_align.sv
// Store lane generator: turns size, low address bits and raw store data into
// lane-replicated write data and byte enables. Misaligned or illegal stores
// get an all-zero strobe so the memory op still completes without writing.
module store_lane_align
  import store_commit_buffer_pkg::*;
(
  input  st_size_t                size_i,
  input  logic [1:0]              addr_lo_i,
  input  logic [SCB_DATA_W-1:0]   data_i,
  output logic [SCB_DATA_W-1:0]   wdata_o,
  output logic [SCB_STRB_W-1:0]   wstrb_o,
  output logic                    misalign_o
);

  // Decode size into lane data and strobes, then suppress strobes on misalignment.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    wdata_o    = '0;
    wstrb_o    = '0;
    misalign_o = 1'b0;
    case (size_i)
      SZ_B: begin
        wdata_o = {4{data_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
      end
      SZ_H: begin
        wdata_o    = {2{data_i[15:0]}};
        wstrb_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        misalign_o = addr_lo_i[0];
      end
      SZ_W: begin
        wdata_o    = data_i;
        wstrb_o    = 4'hF;
        misalign_o = (addr_lo_i != 2'b00);
      end
      default: misalign_o = 1'b1;
    endcase
    if (misalign_o) wstrb_o = '0;
  end

endmodule

// File: rtl/store_commit_buffer.sv
// Post-commit store buffer sitting behind the ROB head. Acks committed stores
// combinationally, queues them in order and drains them to data memory one
// request at a time. Flags loads whose word address aliases a pending store.
// Optional build macro STORE_FWD_EN adds word store-to-load forwarding.
module store_commit_buffer
  import store_commit_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  st_valid_in,
  input  logic [ADDR_WIDTH-1:0] st_addr_in,
  input  logic [DATA_WIDTH-1:0] st_data_in,
  input  logic [1:0]            st_size_in,
  output logic                  st_read_out,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  output logic [3:0]            mem_wstrb_out,
  input  logic                  mem_ack_in,
  input  logic [ADDR_WIDTH-1:0] ld_addr_in,
  output logic                  ld_conflict_out,
`ifdef STORE_FWD_EN
  output logic                  ld_fwd_valid_out,
  output logic [DATA_WIDTH-1:0] ld_fwd_data_out,
`endif
  input  logic                  drain_in,
  output logic                  empty_out,
  output logic                  misalign_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WA_W  = ADDR_WIDTH - 2;

  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0]      count_q;
  logic [DEPTH-1:0]      valid_q;
  scb_entry_t            entry_q [DEPTH];
  logic [WA_W-1:0]       waddr_q [DEPTH];
  scb_state_t            state_q;
  logic                  mem_req_q;
  logic [WA_W-1:0]       mem_waddr_q;
  logic [SCB_DATA_W-1:0] mem_wdata_q;
  logic [SCB_STRB_W-1:0] mem_wstrb_q;
  logic                  misalign_q;

  logic                  full, push, pop;
  logic [SCB_DATA_W-1:0] al_wdata;
  logic [SCB_STRB_W-1:0] al_wstrb;
  logic                  al_misalign;

  logic                  any_hit, youngest_word;
  logic [SCB_DATA_W-1:0] youngest_data;
  logic [PTR_W-1:0]      scan_idx;

  store_lane_align u_align (
    .size_i     (st_size_t'(st_size_in)),
    .addr_lo_i  (st_addr_in[1:0]),
    .data_i     (st_data_in),
    .wdata_o    (al_wdata),
    .wstrb_o    (al_wstrb),
    .misalign_o (al_misalign)
  );

  // Full is judged on the registered count only: a pop in the same cycle does not
  // free a slot early. The ack must stay combinational, or the ROB, which holds
  // st_valid_in until acked, would see a stale ack and retire the head twice.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign st_read_out = st_valid_in & ~full & ~drain_in;
  assign push        = st_read_out;
  assign pop         = (state_q == S_REQ) & mem_ack_in;
  assign rd_ptr_nxt  = rd_ptr_q + PTR_W'(1);

  // FIFO bookkeeping: pointers wrap freely because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= push & al_misalign;
      if (pop) begin
        rd_ptr_q          <= rd_ptr_nxt;
        valid_q[rd_ptr_q] <= 1'b0;
      end
      if (push) begin
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
        valid_q[wr_ptr_q] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage written on the accepting edge.
  always_ff @(posedge clk_in) begin
    // NOTE: storage has no reset; valid_q alone decides which slots mean anything.
    if (push) begin
      entry_q[wr_ptr_q] <= '{wdata: al_wdata, wstrb: al_wstrb};
      waddr_q[wr_ptr_q] <= st_addr_in[ADDR_WIDTH-1:2];
    end
  end

  // Drain FSM with registered memory-side outputs, held stable for the whole request.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q     <= S_REQ;
            mem_req_q   <= 1'b1;
            mem_waddr_q <= waddr_q[rd_ptr_q];
            mem_wdata_q <= entry_q[rd_ptr_q].wdata;
            mem_wstrb_q <= entry_q[rd_ptr_q].wstrb;
          end
        end
        S_REQ: begin
          if (mem_ack_in) begin
            if (count_q > CNT_W'(1)) begin
              mem_waddr_q <= waddr_q[rd_ptr_nxt];
              mem_wdata_q <= entry_q[rd_ptr_nxt].wdata;
              mem_wstrb_q <= entry_q[rd_ptr_nxt].wstrb;
            end else begin
              state_q     <= S_IDLE;
              mem_req_q   <= 1'b0;
              mem_waddr_q <= '0;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '0;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_out   = mem_req_q;
  assign mem_addr_out  = {mem_waddr_q, 2'b00};
  assign mem_wdata_out = mem_wdata_q;
  assign mem_wstrb_out = mem_wstrb_q;
  assign misalign_out  = misalign_q;
  assign empty_out     = (count_q == '0) && (state_q == S_IDLE);

  // Alias scan from oldest to youngest so the last hit is the youngest match.
  always_comb begin
    any_hit       = 1'b0;
    youngest_word = 1'b0;
    youngest_data = '0;
    scan_idx      = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      scan_idx = rd_ptr_q + PTR_W'(k);
      if (valid_q[scan_idx] && (waddr_q[scan_idx] == ld_addr_in[ADDR_WIDTH-1:2])) begin
        any_hit       = 1'b1;
        youngest_word = is_full_word(entry_q[scan_idx].wstrb);
        youngest_data = entry_q[scan_idx].wdata;
      end
    end
  end

`ifdef STORE_FWD_EN
  assign ld_fwd_valid_out = any_hit & youngest_word & (ld_addr_in[1:0] == 2'b00);
  assign ld_fwd_data_out  = ld_fwd_valid_out ? youngest_data : '0;
  assign ld_conflict_out  = any_hit & ~ld_fwd_valid_out;
`else
  assign ld_conflict_out  = any_hit;

  logic unused_fwd;
  assign unused_fwd = ^{youngest_word, youngest_data, ld_addr_in[1:0]};
`endif

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer with hand-computed expectations.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_store_commit_buffer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        st_valid_in;
  logic [31:0] st_addr_in;
  logic [31:0] st_data_in;
  logic [1:0]  st_size_in;
  logic        st_read_out;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_wstrb_out;
  logic        mem_ack_in;
  logic [31:0] ld_addr_in;
  logic        ld_conflict_out;
`ifdef STORE_FWD_EN
  logic        ld_fwd_valid_out;
  logic [31:0] ld_fwd_data_out;
`endif
  logic        drain_in;
  logic        empty_out;
  logic        misalign_out;

  int n_checks = 0;
  int n_errors = 0;

  store_commit_buffer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .st_valid_in      (st_valid_in),
    .st_addr_in       (st_addr_in),
    .st_data_in       (st_data_in),
    .st_size_in       (st_size_in),
    .st_read_out      (st_read_out),
    .mem_req_out      (mem_req_out),
    .mem_addr_out     (mem_addr_out),
    .mem_wdata_out    (mem_wdata_out),
    .mem_wstrb_out    (mem_wstrb_out),
    .mem_ack_in       (mem_ack_in),
    .ld_addr_in       (ld_addr_in),
    .ld_conflict_out  (ld_conflict_out),
`ifdef STORE_FWD_EN
    .ld_fwd_valid_out (ld_fwd_valid_out),
    .ld_fwd_data_out  (ld_fwd_data_out),
`endif
    .drain_in         (drain_in),
    .empty_out        (empty_out),
    .misalign_out     (misalign_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(negedge clk_in);
    #1;
  endtask

  // Presents one store for a single cycle and expects it to be acked.
  task automatic push_one(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    st_valid_in = 1'b1;
    st_addr_in  = addr;
    st_data_in  = data;
    st_size_in  = size;
    #1;
    check("st_read_ack", 32'(st_read_out), 32'd1);
    next();
    st_valid_in = 1'b0;
    #1;
  endtask

  task automatic wait_req(input int max_cycles);
    int n = 0;
    while (mem_req_out !== 1'b1 && n < max_cycles) begin
      next();
      n++;
    end
    check("req_seen", 32'(mem_req_out), 32'd1);
  endtask

  // Waits for the request, checks the presented write, then acks it.
  task automatic ack_one(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    wait_req(8);
    check("mem_addr", mem_addr_out, addr);
    check("mem_wdata", mem_wdata_out, wdata);
    check("mem_wstrb", 32'(mem_wstrb_out), 32'(strb));
    mem_ack_in = 1'b1;
    next();
    mem_ack_in = 1'b0;
    #1;
  endtask

  initial begin
    rst_n_in    = 1'b0;
    st_valid_in = 1'b0;
    st_addr_in  = '0;
    st_data_in  = '0;
    st_size_in  = 2'b00;
    mem_ack_in  = 1'b0;
    ld_addr_in  = '0;
    drain_in    = 1'b0;

    // Reset state
    #12;
    check("rst_st_read", 32'(st_read_out), 32'd0);
    check("rst_req", 32'(mem_req_out), 32'd0);
    check("rst_addr", mem_addr_out, 32'h0);
    check("rst_wstrb", 32'(mem_wstrb_out), 32'h0);
    check("rst_empty", 32'(empty_out), 32'd1);
    check("rst_misalign", 32'(misalign_out), 32'd0);
    check("rst_conflict", 32'(ld_conflict_out), 32'd0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    #1;

    // Word store, request held three cycles before ack
    push_one(32'h100, 32'hDEADBEEF, 2'b10);
    check("w_req_idle", 32'(mem_req_out), 32'd0);
    check("w_not_empty", 32'(empty_out), 32'd0);
    next();
    check("w_addr", mem_addr_out, 32'h100);
    check("w_wdata", mem_wdata_out, 32'hDEADBEEF);
    check("w_wstrb", 32'(mem_wstrb_out), 32'hF);
    for (int i = 0; i < 3; i++) begin
      check("w_req_hold", 32'(mem_req_out), 32'd1);
      check("w_addr_hold", mem_addr_out, 32'h100);
      next();
    end
    mem_ack_in = 1'b1;
    next();
    mem_ack_in = 1'b0;
    #1;
    check("w_req_done", 32'(mem_req_out), 32'd0);
    check("w_empty_done", 32'(empty_out), 32'd1);

    // Byte and half lane generation
    push_one(32'h103, 32'h000000AB, 2'b00);
    ack_one(32'h100, 32'hABABABAB, 4'b1000);
    push_one(32'h102, 32'h1234CDEF, 2'b01);
    ack_one(32'h100, 32'hCDEFCDEF, 4'b1100);

    // Fill to DEPTH with no acks; fifth store waits for the first pop
    for (int i = 0; i < 4; i++)
      push_one(32'h400 + 32'(4 * i), 32'(i + 1), 2'b10);
    st_valid_in = 1'b1;
    st_addr_in  = 32'h410;
    st_data_in  = 32'd5;
    st_size_in  = 2'b10;
    #1;
    check("full_refuse", 32'(st_read_out), 32'd0);
    next();
    check("full_refuse2", 32'(st_read_out), 32'd0);
    check("full_head_addr", mem_addr_out, 32'h400);
    mem_ack_in = 1'b1;
    #1;
    check("full_pop_cycle", 32'(st_read_out), 32'd0);
    next();
    mem_ack_in = 1'b0;
    #1;
    check("full_after_pop", 32'(st_read_out), 32'd1);
    check("full_next_addr", mem_addr_out, 32'h404);
    next();
    st_valid_in = 1'b0;
    #1;
    for (int i = 1; i < 5; i++)
      ack_one(32'h400 + 32'(4 * i), 32'(i + 1), 4'hF);
    check("full_drained", 32'(empty_out), 32'd1);

    // Misaligned word and alias detection
    push_one(32'h201, 32'h11111111, 2'b10);
    check("mis_pulse", 32'(misalign_out), 32'd1);
    ld_addr_in = 32'h204;
    #1;
    check("ld_204_conflict", 32'(ld_conflict_out), 32'd0);
    next();
    check("mis_pulse_end", 32'(misalign_out), 32'd0);
    ld_addr_in = 32'h202;
    #1;
    check("ld_202_conflict", 32'(ld_conflict_out), 32'd1);
`ifdef STORE_FWD_EN
    check("ld_202_fwd", 32'(ld_fwd_valid_out), 32'd0);
`endif
    check("mis_addr", mem_addr_out, 32'h200);
    check("mis_wstrb", 32'(mem_wstrb_out), 32'h0);
    mem_ack_in = 1'b1;
    #1;
    check("ld_ack_cycle", 32'(ld_conflict_out), 32'd1);
    next();
    mem_ack_in = 1'b0;
    #1;
    check("ld_after_pop", 32'(ld_conflict_out), 32'd0);
    check("mis_empty", 32'(empty_out), 32'd1);

    // Two word stores to one address: youngest wins when forwarding
    push_one(32'h300, 32'h00001234, 2'b10);
    push_one(32'h300, 32'h00005678, 2'b10);
    ld_addr_in = 32'h300;
    #1;
`ifdef STORE_FWD_EN
    check("fwd_valid", 32'(ld_fwd_valid_out), 32'd1);
    check("fwd_data", ld_fwd_data_out, 32'h5678);
    check("fwd_conflict", 32'(ld_conflict_out), 32'd0);
`else
    check("dup_conflict", 32'(ld_conflict_out), 32'd1);
`endif
    ld_addr_in = 32'h302;
    #1;
    check("ld_302_conflict", 32'(ld_conflict_out), 32'd1);
`ifdef STORE_FWD_EN
    check("ld_302_fwd", 32'(ld_fwd_valid_out), 32'd0);
`endif
    ld_addr_in = 32'h0;
    ack_one(32'h300, 32'h1234, 4'hF);
    ack_one(32'h300, 32'h5678, 4'hF);

    // Fence blocks acks; reset aborts an in-flight request
    drain_in    = 1'b1;
    st_valid_in = 1'b1;
    st_addr_in  = 32'h500;
    st_data_in  = 32'hCAFEF00D;
    st_size_in  = 2'b10;
    #1;
    check("drain_block", 32'(st_read_out), 32'd0);
    next();
    check("drain_block2", 32'(st_read_out), 32'd0);
    check("drain_empty", 32'(empty_out), 32'd1);
    drain_in = 1'b0;
    #1;
    check("drain_release", 32'(st_read_out), 32'd1);
    next();
    st_valid_in = 1'b0;
    next();
    check("rst_pre_req", 32'(mem_req_out), 32'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req_out), 32'd0);
    check("rst_mid_empty", 32'(empty_out), 32'd1);
    check("rst_mid_addr", mem_addr_out, 32'h0);
    next();
    rst_n_in = 1'b1;
    next();
    next();
    check("rst_post_req", 32'(mem_req_out), 32'd0);
    check("rst_post_empty", 32'(empty_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
